ex_stage_exmem: RTL and testbench

Execute stage plus EX/MEM pipeline register. It sits directly downstream of the ID/EX register and consumes its outputs.
- ALU with operand forwarding, branch/jump resolution, redirect.
- Iterative multiply/divide unit writing HI/LO; stalls the front end while busy.
- Registered EX/MEM outputs feed the memory stage.

---
 rtl/ex_stage_exmem.sv | 249 ++++++++++++++++++++++++
 tb/tb_ex_stage_exmem.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_exmem.sv
// ex_stage_exmem: execute stage with operand forwarding, branch/jump
// resolution, an iterative multiply/divide unit writing HI/LO, and the
// EX/MEM pipeline register feeding the memory stage.
//
// MD state | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no MD op in flight; an 11xx aluop captures operands, stalls
// BUSY     | one shift-add or restoring-subtract step per cycle, stalls
// DONE     | sign-correct, write HI/LO; the MD instruction leaves EX
module ex_stage_exmem #(
    parameter int FWD_EN   = 1,
    parameter int MD_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iPC,
    input  logic [31:0] iIR,
    input  logic [31:0] iread_data1,
    input  logic [31:0] iread_data2,
    input  logic [31:0] isign_ext,
    input  logic [4:0]  iRS1,
    input  logic [4:0]  iRS2,
    input  logic [4:0]  iwrite_addr,
    input  logic [3:0]  ialuop,
    input  logic        ialusrc,
    input  logic        ibranch,
    input  logic        ibranch_yes,
    input  logic [1:0]  ijump,
    input  logic        imem_read,
    input  logic        imem_write,
    input  logic        imem_to_reg,
    input  logic        ipc_to_reg,
    input  logic        ireg_write,
    input  logic        imemwb_reg_write,
    input  logic [4:0]  imemwb_write_addr,
    input  logic [31:0] imemwb_data,
    output logic        ostall,
    output logic        oredirect,
    output logic [31:0] otarget,
    output logic        omem_read,
    output logic        omem_write,
    output logic        omem_to_reg,
    output logic        opc_to_reg,
    output logic        oreg_write,
    output logic [4:0]  owrite_addr,
    output logic [31:0] oalu_result,
    output logic [31:0] ostore_data,
    output logic [31:0] oPC,
    output logic [31:0] oIR
);
    localparam int CW = $clog2(MD_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(MD_STEPS - 1);

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    md_state_e      state_q;
    logic [CW-1:0]  cnt_q;
    logic [63:0]    acc_q;       // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0]    opb_q;       // multiplicand or divisor magnitude
    logic [31:0]    dividend_q;  // raw dividend, returned in HI on divide by zero
    logic           is_div_q, neg_res_q, neg_rem_q, dvz_q;
    logic [31:0]    hi_q, lo_q;
    logic [31:0]    hi_d, lo_d;
    logic [63:0]    prod_fix;

    logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_res;
    logic        exmem_fwd_ok, memwb_fwd_ok;
    logic        md_op, md_start, md_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] mul_next, div_next;
    logic        br_taken;
    logic [4:0]  shamt;

    assign exmem_fwd_ok = oreg_write & ~omem_to_reg & (owrite_addr != 5'd0);
    assign memwb_fwd_ok = imemwb_reg_write & (imemwb_write_addr != 5'd0);

    // Operand forwarding: EX/MEM result beats MEM/WB, which beats the regfile
    always_comb begin
        fwd_a = iread_data1;
        fwd_b = iread_data2;
        if (FWD_EN != 0) begin
            if (exmem_fwd_ok && owrite_addr == iRS1)
                fwd_a = oalu_result;
            else if (memwb_fwd_ok && imemwb_write_addr == iRS1)
                fwd_a = imemwb_data;
            if (exmem_fwd_ok && owrite_addr == iRS2)
                fwd_b = oalu_result;
            else if (memwb_fwd_ok && imemwb_write_addr == iRS2)
                fwd_b = imemwb_data;
        end
    end

    assign op_a  = fwd_a;
    assign op_b  = ialusrc ? isign_ext : fwd_b;
    assign shamt = iIR[10:6];

    // ALU result, with link address and MFHI/MFLO overriding the aluop
    always_comb begin
        alu_res = 32'd0;
        case (ialuop)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0011: alu_res = op_a ^ op_b;
            4'b0100: alu_res = ~(op_a | op_b);
            4'b0101: alu_res = {31'd0, op_a < op_b};
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b1000: alu_res = fwd_b << shamt;
            4'b1001: alu_res = fwd_b >> shamt;
            4'b1010: alu_res = $signed(fwd_b) >>> shamt;
            4'b1011: alu_res = op_b << 16;
            default: alu_res = 32'd0;
        endcase
        if (iIR[31:26] == 6'd0 && iIR[5:0] == 6'h10)
            alu_res = hi_q;
        else if (iIR[31:26] == 6'd0 && iIR[5:0] == 6'h12)
            alu_res = lo_q;
        if (ipc_to_reg)
            alu_res = iPC + 32'd4;
    end

    // Branch/jump resolution in the EX cycle
    always_comb begin
        br_taken  = ibranch & ((op_a == fwd_b) == ibranch_yes);
        oredirect = br_taken | (ijump == 2'b01) | (ijump == 2'b10);
        case (ijump)
            2'b01:   otarget = {iPC[31:28], iIR[25:0], 2'b00};
            2'b10:   otarget = op_a;
            default: otarget = iPC + {isign_ext[29:0], 2'b00};
        endcase
    end

    assign md_op     = (ialuop[3:2] == 2'b11);
    assign md_start  = (state_q == MD_IDLE) && md_op;
    assign ostall    = md_start || (state_q == MD_BUSY);
    assign md_signed = ~ialuop[0];
    assign a_neg     = md_signed & op_a[31];
    assign b_neg     = md_signed & op_b[31];
    assign a_mag     = a_neg ? (32'd0 - op_a) : op_a;
    assign b_mag     = b_neg ? (32'd0 - op_b) : op_b;

    assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
    assign mul_next  = {mul_sum, acc_q[31:1]};
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0],  acc_q[30:0], 1'b1};

    // Final HI/LO values from the unsigned magnitude result
    always_comb begin
        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
        hi_d     = prod_fix[63:32];
        lo_d     = prod_fix[31:0];
        if (is_div_q) begin
            if (dvz_q) begin
                hi_d = dividend_q;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                lo_d = neg_res_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                hi_d = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            end
        end
    end

    // Multiply/divide sequencer with its datapath and HI/LO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            acc_q      <= 64'd0;
            opb_q      <= 32'd0;
            dividend_q <= 32'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dvz_q      <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        acc_q      <= {32'd0, a_mag};
                        opb_q      <= b_mag;
                        dividend_q <= op_a;
                        is_div_q   <= ialuop[1];
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        dvz_q      <= (op_b == 32'd0);
                        cnt_q      <= '0;
                        state_q    <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    if (cnt_q == LAST_STEP) begin
                        cnt_q   <= '0;
                        state_q <= MD_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MD_DONE: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    // EX/MEM register: load when not stalled, otherwise insert a bubble
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            omem_read   <= 1'b0;
            omem_write  <= 1'b0;
            omem_to_reg <= 1'b0;
            opc_to_reg  <= 1'b0;
            oreg_write  <= 1'b0;
            owrite_addr <= 5'd0;
            oalu_result <= 32'd0;
            ostore_data <= 32'd0;
            oPC         <= 32'd0;
            oIR         <= 32'd0;
        end else if (!ostall) begin
            omem_read   <= imem_read;
            omem_write  <= imem_write;
            omem_to_reg <= imem_to_reg;
            opc_to_reg  <= ipc_to_reg;
            oreg_write  <= ireg_write & ~md_op;
            owrite_addr <= iwrite_addr;
            oalu_result <= alu_res;
            ostore_data <= fwd_b;
            oPC         <= iPC;
            oIR         <= iIR;
        end else begin
            omem_read   <= 1'b0;
            omem_write  <= 1'b0;
            omem_to_reg <= 1'b0;
            opc_to_reg  <= 1'b0;
            oreg_write  <= 1'b0;
            owrite_addr <= 5'd0;
        end
    end

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Self-checking bench for ex_stage_exmem: directed scenarios plus randomized
// ALU/forwarding and multiply/divide traffic against a behavioural model.
module tb_ex_stage_exmem;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iPC, iIR, iread_data1, iread_data2, isign_ext, imemwb_data;
    logic [4:0]  iRS1, iRS2, iwrite_addr, imemwb_write_addr;
    logic [3:0]  ialuop;
    logic        ialusrc, ibranch, ibranch_yes, imem_read, imem_write;
    logic        imem_to_reg, ipc_to_reg, ireg_write, imemwb_reg_write;
    logic [1:0]  ijump;
    logic        ostall, oredirect, omem_read, omem_write, omem_to_reg;
    logic        opc_to_reg, oreg_write;
    logic [31:0] otarget, oalu_result, ostore_data, oPC, oIR;
    logic [4:0]  owrite_addr;

    int n_cmp = 0;
    int n_err = 0;

    // model state: expected EX/MEM contents and HI/LO
    logic        m_rw, m_mtr;
    logic [4:0]  m_wa;
    logic [31:0] m_res;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    ex_stage_exmem #(.FWD_EN(1), .MD_STEPS(32)) dut (
        .clock(clock), .reset(reset), .iPC(iPC), .iIR(iIR),
        .iread_data1(iread_data1), .iread_data2(iread_data2), .isign_ext(isign_ext),
        .iRS1(iRS1), .iRS2(iRS2), .iwrite_addr(iwrite_addr), .ialuop(ialuop),
        .ialusrc(ialusrc), .ibranch(ibranch), .ibranch_yes(ibranch_yes), .ijump(ijump),
        .imem_read(imem_read), .imem_write(imem_write), .imem_to_reg(imem_to_reg),
        .ipc_to_reg(ipc_to_reg), .ireg_write(ireg_write),
        .imemwb_reg_write(imemwb_reg_write), .imemwb_write_addr(imemwb_write_addr),
        .imemwb_data(imemwb_data), .ostall(ostall), .oredirect(oredirect),
        .otarget(otarget), .omem_read(omem_read), .omem_write(omem_write),
        .omem_to_reg(omem_to_reg), .opc_to_reg(opc_to_reg), .oreg_write(oreg_write),
        .owrite_addr(owrite_addr), .oalu_result(oalu_result), .ostore_data(ostore_data),
        .oPC(oPC), .oIR(oIR)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (m_rw && !m_mtr && m_wa != 5'd0 && m_wa == rs) return m_res;
        if (imemwb_reg_write && imemwb_write_addr != 5'd0 && imemwb_write_addr == rs)
            return imemwb_data;
        return rf;
    endfunction

    function automatic logic [31:0] m_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] fb,
                                             input logic [31:0] ir, input logic [31:0] pc,
                                             input logic p2r);
        int unsigned sh;
        logic [31:0] fill;
        sh = (ir >> 6) & 32'h1F;
        if (p2r) return pc + 32'd4;
        if ((ir >> 26) == 32'd0 && (ir & 32'h3F) == 32'h10) return m_hi;
        if ((ir >> 26) == 32'd0 && (ir & 32'h3F) == 32'h12) return m_lo;
        fill = (fb >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  return fb << sh;
            4'd9:  return fb >> sh;
            4'd10: return (fb >> sh) | fill;
            4'd11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] m_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        longint sa, sb, p;
        logic signed [31:0] qa, qb;
        case (op)
            4'd12: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
                return 64'(p);
            end
            4'd13: return {32'd0, a} * {32'd0, b};
            4'd14: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qa = a;
                qb = b;
                return {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic set_idle();
        iPC = 32'd0; iIR = 32'd0; iread_data1 = 32'd0; iread_data2 = 32'd0;
        isign_ext = 32'd0; iRS1 = 5'd0; iRS2 = 5'd0; iwrite_addr = 5'd0;
        ialuop = 4'd0; ialusrc = 1'b0; ibranch = 1'b0; ibranch_yes = 1'b0;
        ijump = 2'd0; imem_read = 1'b0; imem_write = 1'b0; imem_to_reg = 1'b0;
        ipc_to_reg = 1'b0; ireg_write = 1'b0; imemwb_reg_write = 1'b0;
        imemwb_write_addr = 5'd0; imemwb_data = 32'd0;
    endtask

    task automatic set_rtype(input logic [3:0] op, input logic [4:0] rs1,
                             input logic [31:0] d1, input logic [4:0] rs2,
                             input logic [31:0] d2, input logic [4:0] wa);
        set_idle();
        ialuop = op; iRS1 = rs1; iread_data1 = d1; iRS2 = rs2; iread_data2 = d2;
        iwrite_addr = wa; ireg_write = 1'b1; iIR = 32'h0000_0020;
    endtask

    // MD op from a clean EX/MEM; counts stall cycles, samples bubble and held PC
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic [9:0] bub, output logic [31:0] pc);
        set_rtype(4'd2, 5'd0, 32'd1, 5'd0, 32'd1, 5'd12);
        iPC = 32'h0000_0044; imem_read = 1'b1;
        @(posedge clock); #1;
        set_rtype(op, 5'd0, a, 5'd0, b, 5'd7);
        iPC = 32'h0000_2000; iIR = 32'h0000_0018;
        stalls = 0; bub = '1; pc = 32'd0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (!ostall) break;
            stalls++;
            if (stalls == 5) begin
                bub = {omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write, owrite_addr};
                pc  = oPC;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        set_rtype(4'd2, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9);
        iIR = 32'h0000_0010;
        @(posedge clock); #1;
        hi = oalu_result;
        iIR = 32'h0000_0012;
        @(posedge clock); #1;
        lo = oalu_result;
        set_idle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({ostall, oredirect, otarget} !== 34'd0) begin
            n_err++; $display("FAIL reset_comb: got %h want 0", {ostall, oredirect, otarget});
        end
        n_cmp++;
        if ({omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write, owrite_addr,
             oalu_result, ostore_data, oPC, oIR} !== 138'd0) begin
            n_err++; $display("FAIL reset_exmem: alu=%h pc=%h ir=%h rw=%b want all 0",
                              oalu_result, oPC, oIR, oreg_write);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_add();
        set_rtype(4'd2, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        @(posedge clock); #1;
        n_cmp++;
        if (oalu_result !== 32'd12) begin
            n_err++; $display("FAIL add_result: got %0d want 12", oalu_result);
        end
        n_cmp++;
        if ({oreg_write, owrite_addr} !== {1'b1, 5'd3}) begin
            n_err++; $display("FAIL add_dest: got rw=%b wa=%0d want rw=1 wa=3", oreg_write, owrite_addr);
        end
        set_idle();
        @(posedge clock); #1;
    endtask

    task automatic test_forward();
        logic [31:0] memwb_val [3] = '{32'd0, 32'd99, 32'd99};
        logic [31:0] exp       [3] = '{32'd2, 32'd2, 32'd98};
        for (int k = 0; k < 3; k++) begin
            set_rtype(4'd2, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3);
            if (k == 2) iwrite_addr = 5'd8;
            @(posedge clock); #1;
            set_rtype(4'd6, 5'd3, 32'd0, 5'd1, 32'd1, 5'd4);
            if (k > 0) begin
                imemwb_reg_write = 1'b1; imemwb_write_addr = 5'd3; imemwb_data = memwb_val[k];
            end
            @(posedge clock); #1;
            n_cmp++;
            if (oalu_result !== exp[k]) begin
                n_err++; $display("FAIL fwd_case%0d: got %0d want %0d", k, oalu_result, exp[k]);
            end
        end
        set_idle();
        @(posedge clock); #1;
    endtask

    task automatic test_branch();
        set_rtype(4'd6, 5'd0, 32'd9, 5'd0, 32'd9, 5'd0);
        ireg_write = 1'b0; iPC = 32'h100; isign_ext = 32'd4; ibranch = 1'b1; ibranch_yes = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({oredirect, otarget} !== {1'b1, 32'h110}) begin
            n_err++; $display("FAIL beq: got redir=%b tgt=%h want 1 00000110", oredirect, otarget);
        end
        ibranch_yes = 1'b0;
        #1;
        n_cmp++;
        if (oredirect !== 1'b0) begin
            n_err++; $display("FAIL bne: got redir=%b want 0", oredirect);
        end
        ibranch = 1'b0; ijump = 2'b01; iPC = 32'hA000_0004; iIR = 32'h0812_3456;
        #1;
        n_cmp++;
        if ({oredirect, otarget} !== {1'b1, 32'hA048_D158}) begin
            n_err++; $display("FAIL jal: got redir=%b tgt=%h want 1 a048d158", oredirect, otarget);
        end
        ijump = 2'b11;
        #1;
        n_cmp++;
        if (oredirect !== 1'b0) begin
            n_err++; $display("FAIL jump_rsvd: got redir=%b want 0", oredirect);
        end
        set_idle();
        @(posedge clock); #1;
    endtask

    task automatic test_random_alu();
        logic [31:0] ea, eb, ob, res, tgt;
        logic        redir, taken;
        logic [9:0]  ctl;
        set_idle();
        @(posedge clock); #1;
        m_rw = 1'b0; m_mtr = 1'b0; m_wa = 5'd0; m_res = 32'd0;
        for (int it = 0; it < 200; it++) begin
            set_idle();
            imemwb_reg_write = 1'($urandom); imemwb_write_addr = 5'($urandom);
            imemwb_data = $urandom;
            case ($urandom_range(0, 2))
                0: iRS1 = m_wa;
                1: iRS1 = imemwb_write_addr;
                default: iRS1 = 5'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: iRS2 = m_wa;
                1: iRS2 = imemwb_write_addr;
                default: iRS2 = 5'($urandom);
            endcase
            iread_data1 = $urandom; iread_data2 = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                iRS2 = iRS1; iread_data2 = iread_data1;
            end
            iPC = $urandom; iIR = $urandom; isign_ext = $urandom;
            ialuop = 4'($urandom_range(0, 11)); ialusrc = 1'($urandom);
            ipc_to_reg = ($urandom_range(0, 7) == 0);
            imem_read = 1'($urandom); imem_write = 1'($urandom); imem_to_reg = 1'($urandom);
            ireg_write = 1'($urandom); iwrite_addr = 5'($urandom);
            ibranch = ($urandom_range(0, 2) == 0); ibranch_yes = 1'($urandom);
            ijump = ibranch ? 2'd0 : 2'($urandom_range(0, 3));
            ea = m_fwd(iRS1, iread_data1);
            eb = m_fwd(iRS2, iread_data2);
            ob = ialusrc ? isign_ext : eb;
            res = m_result(ialuop, ea, ob, eb, iIR, iPC, ipc_to_reg);
            taken = ibranch && ((ea == eb) == ibranch_yes);
            redir = taken || ijump == 2'd1 || ijump == 2'd2;
            if (ijump == 2'd1) tgt = (iPC & 32'hF000_0000) | ((iIR & 32'h03FF_FFFF) << 2);
            else if (ijump == 2'd2) tgt = ea;
            else tgt = iPC + (isign_ext << 2);
            ctl = {imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write, iwrite_addr};
            @(negedge clock);
            n_cmp++;
            if ({ostall, oredirect} !== {1'b0, redir}) begin
                n_err++; $display("FAIL rnd_redirect it%0d: got st=%b rd=%b want 0 %b",
                                  it, ostall, oredirect, redir);
            end
            if (redir) begin
                n_cmp++;
                if (otarget !== tgt) begin
                    n_err++; $display("FAIL rnd_target it%0d: got %h want %h", it, otarget, tgt);
                end
            end
            @(posedge clock); #1;
            n_cmp++;
            if (oalu_result !== res) begin
                n_err++; $display("FAIL rnd_result it%0d op%0d: got %h want %h", it, ialuop, oalu_result, res);
            end
            n_cmp++;
            if ({omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write, owrite_addr} !== ctl) begin
                n_err++; $display("FAIL rnd_ctl it%0d: got %b want %b", it,
                    {omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write, owrite_addr}, ctl);
            end
            n_cmp++;
            if ({ostore_data, oPC, oIR} !== {eb, iPC, iIR}) begin
                n_err++; $display("FAIL rnd_data it%0d: got sd=%h pc=%h want sd=%h pc=%h",
                                  it, ostore_data, oPC, eb, iPC);
            end
            m_rw = ireg_write; m_mtr = imem_to_reg; m_wa = iwrite_addr; m_res = res;
        end
        set_idle();
        @(posedge clock); #1;
    endtask

    task automatic check_md(input string name, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        int          stalls;
        logic [9:0]  bub;
        logic [31:0] pc, hi, lo;
        logic [63:0] exp;
        exp = m_md(op, a, b);
        run_md(op, a, b, stalls, bub, pc);
        n_cmp++;
        if (stalls !== 33) begin
            n_err++; $display("FAIL %s_stall: got %0d cycles want 33", name, stalls);
        end
        n_cmp++;
        if ({bub, pc} !== {10'd0, 32'h44}) begin
            n_err++; $display("FAIL %s_bubble: got ctl=%b pc=%h want 0 00000044", name, bub, pc);
        end
        n_cmp++;
        if ({oreg_write, oIR} !== {1'b0, 32'h18}) begin
            n_err++; $display("FAIL %s_exit: got rw=%b ir=%h want 0 00000018", name, oreg_write, oIR);
        end
        read_hilo(hi, lo);
        m_hi = exp[63:32]; m_lo = exp[31:0];
        n_cmp++;
        if ({hi, lo} !== exp) begin
            n_err++; $display("FAIL %s_hilo: got %h_%h want %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_mult_div();
        check_md("mult_m3x7", 4'd12, 32'hFFFF_FFFD, 32'd7);
        n_cmp++;
        if ({m_hi, m_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_err++; $display("FAIL mult_model: got %h_%h want ffffffff_ffffffeb", m_hi, m_lo);
        end
        check_md("div_m7d2", 4'd14, 32'hFFFF_FFF9, 32'd2);
        check_md("divu_5d0", 4'd15, 32'd5, 32'd0);
        check_md("div_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        check_md("div_m9d0", 4'd14, 32'hFFFF_FFF7, 32'd0);
    endtask

    task automatic test_random_md();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int it = 0; it < 12; it++) begin
            op = 4'($urandom_range(12, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 0) b = 32'd0 - b;
            check_md("rnd_md", op, a, b);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] hi, lo;
        set_rtype(4'd2, 5'd0, 32'd3, 5'd0, 32'd4, 5'd6);
        iPC = 32'h80;
        @(posedge clock); #1;
        set_rtype(4'd12, 5'd0, 32'd1234, 5'd0, 32'd99, 5'd7);
        iIR = 32'h0000_0018;
        @(posedge clock);
        repeat (9) @(posedge clock);
        #3;
        reset = 1'b0;
        set_idle();
        #1;
        n_cmp++;
        if (ostall !== 1'b0) begin
            n_err++; $display("FAIL rstbusy_stall: got %b want 0", ostall);
        end
        n_cmp++;
        if ({omem_read, omem_write, omem_to_reg, opc_to_reg, oreg_write, owrite_addr,
             oalu_result, ostore_data, oPC, oIR} !== 138'd0) begin
            n_err++; $display("FAIL rstbusy_exmem: alu=%h pc=%h want 0", oalu_result, oPC);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        m_hi = 32'd0; m_lo = 32'd0;
        read_hilo(hi, lo);
        n_cmp++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            n_err++; $display("FAIL rstbusy_hilo: got %h_%h want 0_0", hi, lo);
        end
        set_rtype(4'd2, 5'd1, 32'd20, 5'd2, 32'd22, 5'd5);
        @(negedge clock);
        n_cmp++;
        if (ostall !== 1'b0) begin
            n_err++; $display("FAIL rstbusy_add_stall: got %b want 0", ostall);
        end
        @(posedge clock); #1;
        n_cmp++;
        if ({oreg_write, owrite_addr, oalu_result} !== {1'b1, 5'd5, 32'd42}) begin
            n_err++; $display("FAIL rstbusy_add: got rw=%b wa=%0d res=%0d want 1 5 42",
                              oreg_write, owrite_addr, oalu_result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_branch();
        test_random_alu();
        test_mult_div();
        test_random_md();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
